multicycle_control_fsm: RTL and testbench

//  Multicycle successor to the single-cycle control decoder. Sequences each

---
 rtl/multicycle_control_fsm.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for the multicycle datapath. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The fetched instruction is
// latched internally so the decode is stable for the whole instruction.
// Also provides a retired-instruction counter and a memory-wait watchdog.
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous reset, active low
//   ihit       in   instruction memory ready
//   dhit       in   data memory ready
//   imemload   in   fetched instruction, valid when ihit
//   alu_zero   in   ALU result == 0
//   overflow   in   ALU signed overflow
//   iREN       out  instruction read request
//   dREN/dWEN  out  data read / write request
//   IRWrite    out  instruction-register load strobe
//   PCWrite    out  PC update strobe
//   PCSrc      out  0 PC+4, 1 branch target, 2 jump target, 3 rs (JR)
//   RegDst     out  0 rd, 1 rt, 2 r31
//   RegWrite   out  register file write strobe
//   ALUSrc     out  0 rt, 1 extended immediate, 2 shamt
//   MemToReg   out  0 mem, 1 ALU, 2 PC+4, 3 LUI immediate
//   ExtOp      out  1 sign-extend, 0 zero-extend
//   alu_op     out  ALU operation
//   halt       out  sticky halt
//   timeout    out  sticky watchdog flag
//   retired    out  retired instruction count (wraps)
//   dbg_state  out  current FSM state encoding (debug observation)
//
// Memory handshake: a request (iREN, dREN or dWEN) is raised on entry to its
// state and held level-high every cycle until the matching hit is seen; the
// transfer completes in the cycle where request and hit are both high, and
// the request drops on the following cycle.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

module multicycle_control_fsm
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 64,
  parameter bit OVF_HALT = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              alu_zero,
  input  logic              overflow,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic [1:0]        PCSrc,
  output logic [1:0]        RegDst,
  output logic              RegWrite,
  output logic [1:0]        ALUSrc,
  output logic [1:0]        MemToReg,
  output logic              ExtOp,
  output aluop_t            alu_op,
  output logic              halt,
  output logic              timeout,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    RST_S  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALTED = 3'd6
  } state_t;

  // wait_q only has to reach MAX_WAIT-1: the timeout fires on the cycle that
  // would have made it MAX_WAIT.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t             state_q;
  logic [WORD_W-1:0]  ir_q;
  logic [CNT_W-1:0]   retired_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               halt_q;
  logic               timeout_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign opcode         = ir_q[31:26];
  assign funct          = ir_q[5:0];
  assign unused_ir_bits = ^ir_q[25:6];

  // -------------------------------------------------------------------------
  // Instruction decode from the latched IR
  // -------------------------------------------------------------------------
  aluop_t     dec_alu_op;
  logic [1:0] dec_alu_src;
  logic       dec_ext_op;
  logic       dec_known;    // recognised ALU/LUI/memory/branch instruction
  logic       dec_ovf_chk;  // ADD/SUB/ADDI: signed overflow is a fault
  logic       dec_rtype;
  logic       dec_lw;
  logic       dec_sw;
  logic       dec_lui;
  logic       dec_branch;
  logic       dec_jr;

  always_comb begin
    dec_alu_op  = ALU_SLL;
    dec_alu_src = 2'd0;
    dec_ext_op  = 1'b1;
    dec_known   = 1'b0;
    dec_ovf_chk = 1'b0;
    dec_rtype   = 1'b0;
    dec_lw      = 1'b0;
    dec_sw      = 1'b0;
    dec_lui     = 1'b0;
    dec_branch  = 1'b0;
    dec_jr      = (opcode == OP_RTYPE) && (funct == FN_JR);
    case (opcode)
      OP_RTYPE: begin
        dec_rtype = 1'b1;
        dec_known = 1'b1;
        case (funct)
          FN_SLL:  begin dec_alu_op = ALU_SLL; dec_alu_src = 2'd2; end
          FN_SRL:  begin dec_alu_op = ALU_SRL; dec_alu_src = 2'd2; end
          FN_ADD:  begin dec_alu_op = ALU_ADD; dec_ovf_chk = 1'b1; end
          FN_ADDU: dec_alu_op = ALU_ADD;
          FN_SUB:  begin dec_alu_op = ALU_SUB; dec_ovf_chk = 1'b1; end
          FN_SUBU: dec_alu_op = ALU_SUB;
          FN_AND:  dec_alu_op = ALU_AND;
          FN_OR:   dec_alu_op = ALU_OR;
          FN_XOR:  dec_alu_op = ALU_XOR;
          FN_NOR:  dec_alu_op = ALU_NOR;
          FN_SLT:  dec_alu_op = ALU_SLT;
          FN_SLTU: dec_alu_op = ALU_SLTU;
          default: dec_known  = 1'b0;  // unknown funct retires as a NOP
        endcase
      end
      OP_ADDI:  begin dec_known = 1'b1; dec_alu_op = ALU_ADD;  dec_alu_src = 2'd1; dec_ovf_chk = 1'b1; end
      OP_ADDIU: begin dec_known = 1'b1; dec_alu_op = ALU_ADD;  dec_alu_src = 2'd1; end
      OP_SLTI:  begin dec_known = 1'b1; dec_alu_op = ALU_SLT;  dec_alu_src = 2'd1; end
      OP_SLTIU: begin dec_known = 1'b1; dec_alu_op = ALU_SLTU; dec_alu_src = 2'd1; end
      OP_ANDI:  begin dec_known = 1'b1; dec_alu_op = ALU_AND;  dec_alu_src = 2'd1; dec_ext_op = 1'b0; end
      OP_ORI:   begin dec_known = 1'b1; dec_alu_op = ALU_OR;   dec_alu_src = 2'd1; dec_ext_op = 1'b0; end
      OP_XORI:  begin dec_known = 1'b1; dec_alu_op = ALU_XOR;  dec_alu_src = 2'd1; dec_ext_op = 1'b0; end
      // LUI writes the shifted immediate through MemToReg=3; the ALU result is unused.
      OP_LUI:   begin dec_known = 1'b1; dec_lui = 1'b1; dec_alu_src = 2'd1; dec_ext_op = 1'b0; end
      OP_LW:    begin dec_known = 1'b1; dec_lw = 1'b1; dec_alu_op = ALU_ADD; dec_alu_src = 2'd1; end
      OP_SW:    begin dec_known = 1'b1; dec_sw = 1'b1; dec_alu_op = ALU_ADD; dec_alu_src = 2'd1; end
      OP_BEQ, OP_BNE: begin dec_known = 1'b1; dec_branch = 1'b1; dec_alu_op = ALU_SUB; end
      default: ;
    endcase
  end

  logic branch_taken;
  logic ovf_fault;

  assign branch_taken = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
  assign ovf_fault    = OVF_HALT && dec_ovf_chk && overflow;

  // -------------------------------------------------------------------------
  // Datapath controls: decoded from state and latched IR; the hit, alu_zero
  // and overflow inputs only qualify the strobes of the current cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'd0;
    RegDst   = 2'd0;
    RegWrite = 1'b0;
    ALUSrc   = 2'd0;
    MemToReg = 2'd0;
    ExtOp    = 1'b0;
    alu_op   = ALU_SLL;
    case (state_q)
      FETCH: begin
        iREN    = 1'b1;
        IRWrite = ihit;
      end
      DECODE: begin
        if (opcode == OP_J) begin
          PCWrite = 1'b1;
          PCSrc   = 2'd2;
        end else if (opcode == OP_JAL) begin
          PCWrite  = 1'b1;
          PCSrc    = 2'd2;
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemToReg = 2'd2;
        end else if (dec_jr) begin
          PCWrite = 1'b1;
          PCSrc   = 2'd3;
        end
      end
      EXEC: begin
        alu_op = dec_alu_op;
        ALUSrc = dec_alu_src;
        ExtOp  = dec_ext_op;
        if (dec_branch) begin
          PCWrite = 1'b1;
          PCSrc   = branch_taken ? 2'd1 : 2'd0;
        end
      end
      MEM: begin
        // Address operands stay selected while the request is outstanding.
        alu_op = dec_alu_op;
        ALUSrc = dec_alu_src;
        ExtOp  = dec_ext_op;
        dREN   = dec_lw;
        dWEN   = dec_sw;
        if (dec_sw && dhit) begin
          PCWrite = 1'b1;
        end
      end
      WB: begin
        RegWrite = dec_known;
        RegDst   = dec_rtype ? 2'd0 : 2'd1;
        MemToReg = dec_lw ? 2'd0 : (dec_lui ? 2'd3 : 2'd1);
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign halt      = halt_q;
  assign timeout   = timeout_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

  // -------------------------------------------------------------------------
  // State register, IR, retire counter, watchdog
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RST_S;
      ir_q      <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Every PCWrite pulse marks exactly one retired instruction.
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, PCWrite};
      // Wait count only survives consecutive cycles in FETCH/MEM without a hit.
      wait_q    <= '0;
      case (state_q)
        RST_S: state_q <= FETCH;
        FETCH: begin
          if (ihit) begin
            ir_q    <= imemload;
            state_q <= DECODE;
          end else if (MAX_WAIT > 0 && wait_q == WAIT_LAST) begin
            timeout_q <= 1'b1;
            halt_q    <= 1'b1;
            state_q   <= HALTED;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DECODE: begin
          if (opcode == OP_HALT) begin
            halt_q  <= 1'b1;
            state_q <= HALTED;
          end else if (opcode == OP_J || opcode == OP_JAL || dec_jr) begin
            state_q <= FETCH;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (dec_branch) begin
            state_q <= FETCH;
          end else if (ovf_fault) begin
            halt_q  <= 1'b1;
            state_q <= HALTED;
          end else if (dec_lw || dec_sw) begin
            state_q <= MEM;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (dhit) begin
            state_q <= dec_lw ? WB : FETCH;
          end else if (MAX_WAIT > 0 && wait_q == WAIT_LAST) begin
            timeout_q <= 1'b1;
            halt_q    <= 1'b1;
            state_q   <= HALTED;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        WB:      state_q <= FETCH;
        HALTED:  state_q <= HALTED;
        default: state_q <= RST_S;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm (instance built with MAX_WAIT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge that moves the state.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;
  import cpu_types_pkg::*;

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, alu_zero, overflow;
  logic [31:0] imemload;
  logic        iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite, ExtOp, halt, timeout;
  logic [1:0]  PCSrc, RegDst, ALUSrc, MemToReg;
  aluop_t      alu_op;
  logic [31:0] retired;
  logic [2:0]  dbg_state;

  always #5 CLK = ~CLK;

  multicycle_control_fsm #(
    .WORD_W  (32),
    .CNT_W   (32),
    .MAX_WAIT(4),
    .OVF_HALT(1'b1)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ihit     (ihit),
    .dhit     (dhit),
    .imemload (imemload),
    .alu_zero (alu_zero),
    .overflow (overflow),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .ExtOp    (ExtOp),
    .alu_op   (alu_op),
    .halt     (halt),
    .timeout  (timeout),
    .retired  (retired),
    .dbg_state(dbg_state)
  );

  // ---------------- instructions ----------------
  logic [31:0] i_addiu, i_lw, i_sw, i_beq, i_bne, i_add, i_ori, i_sll;
  logic [31:0] i_j, i_jal, i_jr, i_unk, i_halt;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a FETCH cycle start (or 1 ns into it); returns 1 ns into DECODE.
  task automatic do_fetch(input logic [31:0] instr, input string tag);
    ihit = 1'b1;
    imemload = instr;
    #1;
    check({tag, "_fetch_state"}, dbg_state, S_FETCH);
    check({tag, "_iren"}, iREN, 1'b1);
    check({tag, "_irwrite"}, IRWrite, 1'b1);
    @(negedge CLK);
    ihit = 1'b0;
    imemload = '0;
    #1;
    check({tag, "_decode_state"}, dbg_state, S_DECODE);
  endtask

  task automatic end_instr(input string tag, input logic [31:0] exp_ret);
    @(negedge CLK);
    #1;
    check({tag, "_back_to_fetch"}, dbg_state, S_FETCH);
    check({tag, "_retired"}, retired, exp_ret);
  endtask

  // exp_ext / exp_alu: a value of 2 / -1 means "not checked"
  task automatic run_alu(input string tag, input logic [31:0] instr, input int exp_alu,
                         input logic [1:0] exp_src, input logic [1:0] exp_ext,
                         input logic [1:0] exp_regdst, input logic [31:0] exp_ret);
    do_fetch(instr, tag);
    @(negedge CLK);
    #1;
    check({tag, "_exec_state"}, dbg_state, S_EXEC);
    if (exp_alu >= 0) check({tag, "_aluop"}, alu_op, exp_alu);
    check({tag, "_alusrc"}, ALUSrc, exp_src);
    if (exp_ext != 2'd2) check({tag, "_extop"}, ExtOp, exp_ext);
    check({tag, "_exec_regwrite"}, RegWrite, 1'b0);
    @(negedge CLK);
    #1;
    check({tag, "_wb_state"}, dbg_state, S_WB);
    check({tag, "_wb_regwrite"}, RegWrite, 1'b1);
    check({tag, "_wb_regdst"}, RegDst, exp_regdst);
    check({tag, "_wb_memtoreg"}, MemToReg, 2'd1);
    check({tag, "_wb_pcwrite"}, {PCWrite, PCSrc}, {1'b1, 2'd0});
    end_instr(tag, exp_ret);
  endtask

  task automatic run_branch(input string tag, input logic [31:0] instr, input logic zero,
                            input logic [1:0] exp_pcsrc, input logic [31:0] exp_ret);
    do_fetch(instr, tag);
    check({tag, "_decode_pcwrite"}, PCWrite, 1'b0);
    @(negedge CLK);
    alu_zero = zero;
    #1;
    check({tag, "_exec_state"}, dbg_state, S_EXEC);
    check({tag, "_aluop"}, alu_op, ALU_SUB);
    check({tag, "_pcwrite"}, PCWrite, 1'b1);
    check({tag, "_pcsrc"}, PCSrc, exp_pcsrc);
    check({tag, "_regwrite"}, RegWrite, 1'b0);
    end_instr(tag, exp_ret);
    alu_zero = 1'b0;
  endtask

  task automatic run_jump(input string tag, input logic [31:0] instr, input logic [1:0] exp_pcsrc,
                          input logic exp_rw, input logic [31:0] exp_ret);
    do_fetch(instr, tag);
    check({tag, "_pcwrite"}, PCWrite, 1'b1);
    check({tag, "_pcsrc"}, PCSrc, exp_pcsrc);
    check({tag, "_regwrite"}, RegWrite, exp_rw);
    if (exp_rw) check({tag, "_link"}, {RegDst, MemToReg}, {2'd2, 2'd2});
    end_instr(tag, exp_ret);
  endtask

  task automatic pulse_reset;
    nRST = 1'b0;
    #1;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_addiu = {6'h09, 5'd0, 5'd1, 16'd5};
    i_lw    = {6'h23, 5'd1, 5'd2, 16'd0};
    i_sw    = {6'h2B, 5'd1, 5'd2, 16'd0};
    i_beq   = {6'h04, 5'd1, 5'd2, 16'd4};
    i_bne   = {6'h05, 5'd1, 5'd2, 16'd4};
    i_add   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    i_ori   = {6'h0D, 5'd1, 5'd2, 16'h00FF};
    i_sll   = {6'h00, 5'd0, 5'd1, 5'd2, 5'd3, 6'h00};
    i_j     = {6'h02, 26'd16};
    i_jal   = {6'h03, 26'd16};
    i_jr    = {6'h00, 5'd31, 15'd0, 6'h08};
    i_unk   = {6'h3E, 26'd0};
    i_halt  = {6'h3F, 26'd0};

    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; alu_zero = 1'b0; overflow = 1'b0; imemload = '0;
    @(negedge CLK);
    #1;
    check("rst_state", dbg_state, S_RST);
    check("rst_outputs", {iREN, dREN, dWEN, IRWrite, PCWrite, PCSrc, RegDst, RegWrite,
                          ALUSrc, MemToReg, ExtOp, alu_op, halt, timeout}, '0);
    check("rst_retired", retired, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    check("first_fetch_state", dbg_state, S_FETCH);
    check("first_fetch_iren", {iREN, IRWrite}, 2'b10);
    @(negedge CLK);

    // ADDIU r1,r0,5 with immediate ihit: expected state trace via queue
    exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    exp_q.push_back(S_EXEC);
    exp_q.push_back(S_WB);
    exp_q.push_back(S_FETCH);
    for (int c = 0; c < 5; c++) begin
      ihit = (c == 0);
      imemload = i_addiu;
      #1;
      check("addiu_state", dbg_state, exp_q.pop_front());
      case (c)
        0: check("addiu_irwrite", IRWrite, 1'b1);
        1: check("addiu_decode_pcwrite", PCWrite, 1'b0);
        2: check("addiu_exec", {alu_op, ALUSrc, ExtOp, RegWrite}, {ALU_ADD, 2'd1, 1'b1, 1'b0});
        3: check("addiu_wb", {RegWrite, RegDst, MemToReg, PCWrite, PCSrc},
                 {1'b1, 2'd1, 2'd1, 1'b1, 2'd0});
        default: check("addiu_retired", retired, 32'd1);
      endcase
      @(negedge CLK);
    end
    ihit = 1'b0;

    // LW with dhit delayed 3 cycles: dREN high for exactly 4 MEM cycles
    do_fetch(i_lw, "lw");
    @(negedge CLK);
    #1;
    check("lw_exec", {dbg_state, alu_op, ALUSrc, dREN}, {S_EXEC, ALU_ADD, 2'd1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      dhit = (i == 3);
      #1;
      check("lw_mem_state", dbg_state, S_MEM);
      check("lw_mem_req", {dREN, dWEN, RegWrite, PCWrite}, 4'b1000);
    end
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    check("lw_wb", {dbg_state, dREN, RegWrite, RegDst, MemToReg, PCWrite},
          {S_WB, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1});
    end_instr("lw", 32'd2);

    run_branch("beq_taken", i_beq, 1'b1, 2'd1, 32'd3);
    run_branch("beq_not_taken", i_beq, 1'b0, 2'd0, 32'd4);
    run_branch("bne_taken", i_bne, 1'b0, 2'd1, 32'd5);

    run_alu("ori", i_ori, ALU_OR, 2'd1, 2'd0, 2'd1, 32'd6);
    run_alu("sll", i_sll, ALU_SLL, 2'd2, 2'd2, 2'd0, 32'd7);

    run_jump("j", i_j, 2'd2, 1'b0, 32'd8);
    run_jump("jal", i_jal, 2'd2, 1'b1, 32'd9);
    run_jump("jr", i_jr, 2'd3, 1'b0, 32'd10);

    // Unknown opcode behaves as a NOP: retires through WB without a register write
    do_fetch(i_unk, "unk");
    @(negedge CLK);
    #1;
    check("unk_exec_state", dbg_state, S_EXEC);
    @(negedge CLK);
    #1;
    check("unk_wb", {dbg_state, RegWrite, PCWrite, PCSrc}, {S_WB, 1'b0, 1'b1, 2'd0});
    end_instr("unk", 32'd11);

    // SW with dhit on the second MEM cycle
    do_fetch(i_sw, "sw");
    @(negedge CLK);
    #1;
    check("sw_exec", {dbg_state, alu_op, ALUSrc}, {S_EXEC, ALU_ADD, 2'd1});
    @(negedge CLK);
    #1;
    check("sw_mem_wait", {dbg_state, dWEN, dREN, PCWrite}, {S_MEM, 1'b1, 1'b0, 1'b0});
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    check("sw_mem_hit", {dWEN, PCWrite, PCSrc, RegWrite}, {1'b1, 1'b1, 2'd0, 1'b0});
    end_instr("sw", 32'd12);
    dhit = 1'b0;

    // Three FETCH wait cycles (this one included), hit on the 4th: the hit wins
    @(negedge CLK);
    #1;
    check("wd_wait2", {dbg_state, timeout}, {S_FETCH, 1'b0});
    @(negedge CLK);
    #1;
    check("wd_wait3", {dbg_state, timeout}, {S_FETCH, 1'b0});
    @(negedge CLK);
    do_fetch(i_addiu, "wd_hit_wins");
    check("wd_hit_wins_flags", {timeout, halt}, 2'b00);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("wd_hit_wins_wb", {dbg_state, RegWrite}, {S_WB, 1'b1});
    end_instr("wd_hit_wins", 32'd13);

    // Reset while SW waits in MEM
    do_fetch(i_sw, "rst_sw");
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst_sw_mem_dwen", {dbg_state, dWEN}, {S_MEM, 1'b1});
    #1;
    nRST = 1'b0;
    #1;
    check("rst_sw_dwen_drop", {dbg_state, dWEN, RegWrite, PCWrite}, {S_RST, 3'b000});
    check("rst_sw_retired", retired, 32'd0);
    @(negedge CLK);
    #1;
    check("rst_sw_held", dbg_state, S_RST);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    check("rst_sw_restart", {dbg_state, retired}, {S_FETCH, 32'd0});

    // ADD with overflow halts without writing or retiring
    do_fetch(i_add, "ovf");
    @(negedge CLK);
    overflow = 1'b1;
    #1;
    check("ovf_exec", {dbg_state, alu_op, PCWrite, RegWrite}, {S_EXEC, ALU_ADD, 1'b0, 1'b0});
    @(negedge CLK);
    overflow = 1'b0;
    #1;
    check("ovf_halted", {dbg_state, halt, timeout, RegWrite, PCWrite, iREN},
          {S_HALTED, 1'b1, 1'b0, 3'b000});
    check("ovf_retired", retired, 32'd0);
    @(negedge CLK);
    #1;
    check("ovf_absorbing", {dbg_state, halt}, {S_HALTED, 1'b1});

    // Watchdog: ihit held low, MAX_WAIT=4
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("wd_fetch_wait", {dbg_state, iREN, timeout, halt}, {S_FETCH, 1'b1, 2'b00});
      @(negedge CLK);
    end
    #1;
    check("wd_timeout", {dbg_state, timeout, halt, iREN}, {S_HALTED, 1'b1, 1'b1, 1'b0});

    // HALT instruction: no retire, no timeout
    pulse_reset();
    do_fetch(i_halt, "halt");
    check("halt_decode", {PCWrite, halt}, 2'b00);
    @(negedge CLK);
    #1;
    check("halt_state", {dbg_state, halt, timeout, retired}, {S_HALTED, 1'b1, 1'b0, 32'd0});

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete, checks so far %0d", n_checks);
    $fatal(1);
  end

endmodule
